// File: rtl/maxnet_n_if.sv
// Request/result bundle for the maxnet_n winner-take-all engine.
//
// Handshake: start is a request that the engine samples only while busy is
// low (and rst is low). done is a one-cycle valid pulse. The result fields
// are valid while done is high and stay stable until the next accepted start.
// When a start is accepted the result fields clear. There is no backpressure;
// the requester must not rely on a start issued while busy is high.
interface maxnet_n_if #(
  parameter int N  = 4,
  parameter int W  = 32,
  parameter int IW = 8
);
  localparam int LN = (N > 1) ? $clog2(N) : 1;

  logic            start;
  logic [W-1:0]    epsilon;
  logic [N*W-1:0]  a_in;
  logic            busy;
  logic            done;
  logic [LN-1:0]   winner_idx;
  logic [W-1:0]    out;
  logic [IW-1:0]   iterations;
  logic            no_winner;
  logic            timeout;
  logic [2:0]      dbg_state;

  modport master (
    output start, epsilon, a_in,
    input  busy, done, winner_idx, out, iterations, no_winner, timeout, dbg_state
  );

  modport slave (
    input  start, epsilon, a_in,
    output busy, done, winner_idx, out, iterations, no_winner, timeout, dbg_state
  );
endinterface

// File: rtl/maxnet_n.sv
// Iterative MAXNET winner-take-all engine. Each iteration sums all
// activations, then rewrites every channel as max(0, a_i - eps*(sum - a_i))
// one channel per cycle, then commits the new set. Stops when at most one
// channel is non-zero or when the iteration cap is reached.
module maxnet_n #(
  parameter int N        = 4,
  parameter int W        = 32,
  parameter int FRAC     = 16,
  parameter int MAX_ITER = 255,
  parameter int IW       = 8
) (
  input  logic        clk,
  input  logic        rst,
  maxnet_n_if.slave   bus
);
  localparam int LN = (N > 1) ? $clog2(N) : 1;
  localparam int AW = W + LN;        // sum of N W-bit values never overflows
  localparam int PW = W + AW;        // full eps * (sum - a_i) product
  localparam int CW = $clog2(N + 1); // non-zero channel count
  localparam logic [LN-1:0] LAST_IDX = LN'(N - 1);
  localparam logic [IW-1:0] ITER_CAP = IW'(MAX_ITER);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_SUM, S_UPDATE, S_COMMIT, S_DONE
  } state_t;

  state_t         state_q;
  logic [W-1:0]   a_q [N];
  logic [W-1:0]   b_q [N];
  logic [W-1:0]   eps_q;
  logic [AW-1:0]  acc_q;
  logic [LN-1:0]  idx_q;
  logic [IW-1:0]  iter_q;

  logic           done_q;
  logic [LN-1:0]  widx_q;
  logic [W-1:0]   out_q;
  logic [IW-1:0]  iters_q;
  logic           nw_q;
  logic           to_q;

  logic [CW-1:0]  nz_d;
  logic [LN-1:0]  win_d;
  logic [W-1:0]   win_val_d;
  logic [AW-1:0]  others_d;
  logic [PW-1:0]  prod_d;
  logic [PW-1:0]  p_d;
  logic [W-1:0]   b_d;

  // Count non-zero channels and find the lowest-index non-zero one.
  always_comb begin
    nz_d      = '0;
    win_d     = '0;
    win_val_d = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (a_q[i] != '0) begin
        nz_d      = nz_d + CW'(1);
        win_d     = LN'(i);
        win_val_d = a_q[i];
      end
    end
  end

  // Inhibited value of channel idx_q, clamped at zero, from the old a[].
  always_comb begin
    others_d = acc_q - AW'(a_q[idx_q]);
    prod_d   = PW'(eps_q) * PW'(others_d);
    p_d      = prod_d >> FRAC;
    b_d      = (p_d >= PW'(a_q[idx_q])) ? '0 : a_q[idx_q] - p_d[W-1:0];
  end

  // Controller, datapath registers and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      for (int i = 0; i < N; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
      eps_q   <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      iter_q  <= '0;
      done_q  <= 1'b0;
      widx_q  <= '0;
      out_q   <= '0;
      iters_q <= '0;
      nw_q    <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            for (int i = 0; i < N; i++) a_q[i] <= bus.a_in[i*W +: W];
            eps_q   <= bus.epsilon;
            iter_q  <= '0;
            widx_q  <= '0;
            out_q   <= '0;
            iters_q <= '0;
            nw_q    <= 1'b0;
            to_q    <= 1'b0;
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (nz_d <= CW'(1) || iter_q == ITER_CAP) begin
            widx_q  <= win_d;
            out_q   <= win_val_d;
            iters_q <= iter_q;
            nw_q    <= (nz_d == '0);
            to_q    <= (nz_d > CW'(1));
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            idx_q   <= '0;
            acc_q   <= '0;
            state_q <= S_SUM;
          end
        end
        S_SUM: begin
          acc_q <= acc_q + AW'(a_q[idx_q]);
          if (idx_q == LAST_IDX) begin
            idx_q   <= '0;
            state_q <= S_UPDATE;
          end else begin
            idx_q <= idx_q + LN'(1);
          end
        end
        S_UPDATE: begin
          b_q[idx_q] <= b_d;
          if (idx_q == LAST_IDX) begin
            idx_q   <= '0;
            state_q <= S_COMMIT;
          end else begin
            idx_q <= idx_q + LN'(1);
          end
        end
        S_COMMIT: begin
          for (int i = 0; i < N; i++) a_q[i] <= b_q[i];
          iter_q  <= iter_q + IW'(1);
          state_q <= S_CHECK;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = done_q;
  assign bus.winner_idx = widx_q;
  assign bus.out        = out_q;
  assign bus.iterations = iters_q;
  assign bus.no_winner  = nw_q;
  assign bus.timeout    = to_q;
  assign bus.dbg_state  = state_q;
endmodule

// File: tb/tb_maxnet_n.sv
// Bench for maxnet_n (N=4, W=32, FRAC=16, MAX_ITER=3). A behavioural model
// computes final activations with wide integer arithmetic; one compare
// process checks busy/done/results every cycle against the expected queue.
module tb_maxnet_n;
  localparam int N        = 4;
  localparam int W        = 32;
  localparam int FRAC     = 16;
  localparam int MAX_ITER = 3;
  localparam int IW       = 8;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned cyc = 0;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  maxnet_n_if #(.N(N), .W(W), .IW(IW)) bus ();

  maxnet_n #(.N(N), .W(W), .FRAC(FRAC), .MAX_ITER(MAX_ITER), .IW(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int unsigned start_cyc;
    int unsigned done_cyc;
    logic [1:0]  widx;
    logic [31:0] val;
    logic [7:0]  iters;
    logic        nw;
    logic        to;
  } res_t;

  res_t exp_q[$];
  res_t last;
  res_t cur;

  function automatic res_t zero_res();
    res_t r;
    r.start_cyc = 0; r.done_cyc = 0; r.widx = '0; r.val = '0;
    r.iters = '0; r.nw = 1'b0; r.to = 1'b0;
    return r;
  endfunction

  // ---------------- behavioural model ----------------
  function automatic res_t model(input logic [31:0] a0, a1, a2, a3,
                                 input logic [31:0] e, input int cap);
    logic [127:0] v [4];
    logic [127:0] nv [4];
    logic [127:0] tot;
    logic [127:0] p;
    int nz;
    int k;
    bit stop;
    res_t r;
    v[0] = 128'(a0); v[1] = 128'(a1); v[2] = 128'(a2); v[3] = 128'(a3);
    k = 0; nz = 0; stop = 1'b0;
    while (!stop) begin
      nz = 0; tot = '0;
      for (int i = 0; i < 4; i++) begin
        if (v[i] != 0) nz++;
        tot = tot + v[i];
      end
      if (nz <= 1 || k == cap) begin
        stop = 1'b1;
      end else begin
        for (int i = 0; i < 4; i++) begin
          p = (128'(e) * (tot - v[i])) >> FRAC;
          nv[i] = (p >= v[i]) ? 128'(0) : v[i] - p;
        end
        for (int i = 0; i < 4; i++) v[i] = nv[i];
        k++;
      end
    end
    r = zero_res();
    for (int i = 3; i >= 0; i--) begin
      if (v[i] != 0) begin
        r.widx = 2'(i);
        r.val  = 32'(v[i]);
      end
    end
    r.iters    = 8'(k);
    r.nw       = (nz == 0);
    r.to       = (nz > 1);
    r.done_cyc = 2 + k * (2 * N + 2);
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  // One compare process: checks outputs on every cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0 && cyc > exp_q[0].start_cyc) begin
      cur = exp_q[0];
      chk("busy_run", 64'(bus.busy), 64'd1);
      if (cyc < cur.done_cyc) begin
        chk("done_early", 64'(bus.done), 64'd0);
        chk("clr_widx",   64'(bus.winner_idx), 64'd0);
        chk("clr_out",    64'(bus.out), 64'd0);
        chk("clr_iters",  64'(bus.iterations), 64'd0);
        chk("clr_flags",  64'({bus.no_winner, bus.timeout}), 64'd0);
      end else begin
        chk("done_pulse", 64'(bus.done), 64'd1);
        chk("winner_idx", 64'(bus.winner_idx), 64'(cur.widx));
        chk("out",        64'(bus.out), 64'(cur.val));
        chk("iterations", 64'(bus.iterations), 64'(cur.iters));
        chk("no_winner",  64'(bus.no_winner), 64'(cur.nw));
        chk("timeout",    64'(bus.timeout), 64'(cur.to));
        last = cur;
        void'(exp_q.pop_front());
      end
    end else begin
      chk("busy_idle",  64'(bus.busy), 64'd0);
      chk("done_idle",  64'(bus.done), 64'd0);
      chk("hold_widx",  64'(bus.winner_idx), 64'(last.widx));
      chk("hold_out",   64'(bus.out), 64'(last.val));
      chk("hold_iters", 64'(bus.iterations), 64'(last.iters));
      chk("hold_nw",    64'(bus.no_winner), 64'(last.nw));
      chk("hold_to",    64'(bus.timeout), 64'(last.to));
    end
  end

  // ---------------- driver tasks ----------------
  // Runs one vector; hand-computed pins check the model, the compare
  // process checks the DUT. extra_at > 0 pulses start at that cycle offset.
  task automatic run_vec(input string name,
                         input logic [31:0] a0, a1, a2, a3, e,
                         input logic [1:0] pw, input logic [31:0] pv,
                         input logic [7:0] pit, input logic pnw, input logic pto,
                         input int unsigned plat, input int extra_at);
    res_t r;
    r = model(a0, a1, a2, a3, e, MAX_ITER);
    chk({name, ".pin_widx"}, 64'(r.widx), 64'(pw));
    chk({name, ".pin_out"},  64'(r.val), 64'(pv));
    chk({name, ".pin_iter"}, 64'(r.iters), 64'(pit));
    chk({name, ".pin_flags"}, 64'({r.nw, r.to}), 64'({pnw, pto}));
    chk({name, ".pin_lat"},  64'(r.done_cyc), 64'(plat));
    @(negedge clk); #1;
    bus.a_in    = {a3, a2, a1, a0};
    bus.epsilon = e;
    bus.start   = 1'b1;
    r.start_cyc = cyc;
    r.done_cyc  = r.done_cyc + cyc;
    exp_q.push_back(r);
    @(negedge clk); #1;
    bus.start = 1'b0;
    for (int n = 1; n < 200 && exp_q.size() != 0; n++) begin
      bus.start = (n == extra_at);
      @(negedge clk); #1;
    end
    bus.start = 1'b0;
    chk({name, ".completed"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
  endtask

  // Starts the single-winner vector and resets during UPDATE.
  task automatic abort_run();
    res_t r;
    r = model(32'h10000, 32'h8000, 32'h0, 32'h0, 32'h8000, MAX_ITER);
    @(negedge clk); #1;
    bus.a_in    = {32'h0, 32'h0, 32'h8000, 32'h10000};
    bus.epsilon = 32'h8000;
    bus.start   = 1'b1;
    r.start_cyc = cyc;
    r.done_cyc  = r.done_cyc + cyc;
    exp_q.push_back(r);
    @(negedge clk); #1;
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    last = zero_res();
    @(negedge clk); #1;
    rst = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.start   = 1'b0;
    bus.epsilon = '0;
    bus.a_in    = '0;
    last        = zero_res();
    rst         = 1'b1;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;

    run_vec("single",   32'h10000, 32'h8000, 32'h0, 32'h0, 32'h8000,
            2'd0, 32'hC000, 8'd1, 1'b0, 1'b0, 12, 0);
    run_vec("resolved", 32'h0, 32'h0, 32'h1234, 32'h0, 32'h8000,
            2'd2, 32'h1234, 8'd0, 1'b0, 1'b0, 2, 0);
    run_vec("tie_zero", 32'h8000, 32'h8000, 32'h0, 32'h0, 32'h10000,
            2'd0, 32'h0, 8'd1, 1'b1, 1'b0, 12, 0);
    run_vec("timeout",  32'h8000, 32'h8000, 32'h0, 32'h0, 32'h8000,
            2'd0, 32'h1000, 8'd3, 1'b0, 1'b1, 32, 0);
    run_vec("clamp",    32'hFFFFFFFF, 32'h1, 32'h1, 32'h1, 32'hFFFFFFFF,
            2'd0, 32'hFFFD0000, 8'd1, 1'b0, 1'b0, 12, 0);
    run_vec("all_zero", 32'h0, 32'h0, 32'h0, 32'h0, 32'h8000,
            2'd0, 32'h0, 8'd0, 1'b1, 1'b0, 2, 0);
    run_vec("top_only", 32'h0, 32'h0, 32'h0, 32'h20, 32'h0,
            2'd3, 32'h20, 8'd0, 1'b0, 1'b0, 2, 0);
    run_vec("eps_zero", 32'h1, 32'h0, 32'h2, 32'h0, 32'h0,
            2'd0, 32'h1, 8'd3, 1'b0, 1'b1, 32, 0);
    run_vec("three_ch", 32'h30000, 32'h10000, 32'h10000, 32'h0, 32'h4000,
            2'd0, 32'h28000, 8'd1, 1'b0, 1'b0, 12, 0);
    run_vec("two_iter", 32'h10000, 32'h0, 32'h0, 32'h18000, 32'h8000,
            2'd3, 32'hE000, 8'd2, 1'b0, 1'b0, 22, 0);
    run_vec("start_in_sum", 32'h10000, 32'h8000, 32'h0, 32'h0, 32'h8000,
            2'd0, 32'hC000, 8'd1, 1'b0, 1'b0, 12, 3);

    abort_run();

    // start in the same cycle as rst must not launch a run
    @(negedge clk); #1;
    bus.a_in    = {32'h0, 32'h0, 32'h0, 32'h777};
    bus.start   = 1'b1;
    rst         = 1'b1;
    last        = zero_res();
    @(negedge clk); #1;
    bus.start = 1'b0;
    rst       = 1'b0;
    repeat (4) @(negedge clk);

    run_vec("after_abort", 32'h10000, 32'h0, 32'h0, 32'h18000, 32'h8000,
            2'd3, 32'hE000, 8'd2, 1'b0, 1'b0, 22, 0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/maxnet_n.md
Name: maxnet_n

Overview:
- Parametrised, iterative MAXNET winner-take-all engine; successor to the fixed 4-input, 32-bit Maxnet datapath/controller pair.
- N unsigned fixed-point activations are updated each iteration by a_i <= max(0, a_i - eps * sum over j!=i of a_j).
- Iteration stops when at most one activation is non-zero, or when an iteration cap is reached.
- Reports winner index, winner value, iteration count and status flags to the surrounding inference logic.

Parameters:
- N, 4: number of channels (>=2).
- W, 32: activation and epsilon width.
- FRAC, 16: fractional bits; all values are unsigned Q(W-FRAC).FRAC.
- MAX_ITER, 255: iteration cap (>=1).
- IW, 8: width of the iteration counter; must hold MAX_ITER.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  start request; sampled only in IDLE.
- epsilon  in  W  inhibition weight, Q format.
- a_in  in  N*W  initial activations; channel i is at bits [i*W +: W].
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when results are valid.
- winner_idx  out  clog2(N)  winning channel.
- out  out  W  final activation of winner_idx.
- iterations  out  IW  completed iterations.
- no_winner  out  1  all activations reached zero.
- timeout  out  1  cap reached with more than one non-zero activation.

Behaviour:
- Reset: state IDLE. busy, done, winner_idx, out, iterations, no_winner, timeout are all 0; internal registers cleared. Reset overrides everything, including mid-operation; no done is produced for the aborted run.
- States: IDLE, CHECK, SUM, UPDATE, COMMIT, DONE.
- IDLE:
  - On start=1, capture a_in into a[0..N-1] and epsilon into eps; clear iter; go to CHECK.
  - Result outputs hold their previous values until this capture, then clear.
- CHECK (1 cycle): nz = count of non-zero a[i].
  - nz<=1 -> DONE.
  - Else if iter==MAX_ITER -> DONE with timeout.
  - Else -> SUM with idx=0, acc=0.
- SUM (N cycles): acc += a[idx], idx++. acc width is W+clog2(N), so it cannot overflow.
- UPDATE (N cycles), per channel idx, using the old a[] values:
  - p = (eps * (acc - a[idx])) >> FRAC, truncated toward zero, full width kept.
  - b[idx] = (p >= a[idx]) ? 0 : a[idx] - p.
- COMMIT (1 cycle): a <= b; iter++; go to CHECK.
- Iteration timing: exactly 2N+2 cycles. A start sampled at cycle 0 gives CHECK at cycle 1.
- DONE (1 cycle): done=1; go to IDLE. Outputs are registered on entry to DONE and held until the next start capture.
  - winner_idx: lowest index with a[i]!=0, else 0.
  - out: a[winner_idx], or 0 when no non-zero activation remains.
  - iterations: iter.
  - no_winner: 1 iff nz==0.
  - timeout: 1 iff nz>1.
  - no_winner and timeout are never both 1.
- start while busy is ignored. start in the same cycle as rst is ignored.
- Equal non-zero values decay identically. Ties therefore end in no_winner or timeout, never a false winner.
- Epsilon=0 with nz>1 always ends in timeout after MAX_ITER iterations.

Test Plan (N=4, W=32, FRAC=16 unless stated):
- Single winner: a=[0x10000,0x8000,0,0], eps=0x8000, start at cycle 0 -> done at cycle 12; winner_idx=0, out=0xC000, iterations=1, flags 0.
- Already resolved: a=[0,0,0x1234,0], start at cycle 0 -> done at cycle 2; winner_idx=2, out=0x1234, iterations=0.
- Exact tie to zero: a=[0x8000,0x8000,0,0], eps=0x10000 -> no_winner=1, winner_idx=0, out=0, iterations=1.
- Timeout, MAX_ITER=3: a=[0x8000,0x8000,0,0], eps=0x8000 -> timeout=1, iterations=3, winner_idx=0, out=0x1000.
- Robustness:
  - start pulsed during SUM -> ignored; results identical to the first scenario.
  - rst asserted during UPDATE -> next cycle is IDLE, all outputs 0, no done pulse.
  - A subsequent start runs cleanly.
- Clamp and width: eps=0xFFFFFFFF, a=[0xFFFFFFFF,1,1,1] -> channels 1-3 clamp to 0 without wrap; winner_idx=0, out=0xFFFFFFFF - ((0xFFFFFFFF*3)>>16), iterations=1.
